me_anim_ctrl: RTL

//  Animation sequencer for the player ("Me") sprite. Produces the 8-bit state code that

---
 rtl/me_anim_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/me_anim_ctrl.sv
// Animation sequencer for the player sprite.
// Produces the sprite ROM frame code, which alternates between idle and walk poses.
// Also runs a five-phase attack sequence and flags the strike window and attack end.
// Frames advance on ticks derived from the asynchronous vertical-frame strobe.
module me_anim_ctrl #(
   parameter int unsigned WALK_FRAMES = 8,
   parameter int unsigned ATK_FRAMES  = 4
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_clk,
   input  logic       move,
   input  logic       attack_req,
   output logic [7:0] state,
   output logic       busy,
   output logic       hit,
   output logic       attack_done
);

   typedef enum logic [7:0] {
      IDLE = 8'h01,
      WALK = 8'h02,
      A0   = 8'h06,
      A1   = 8'h07,
      A2   = 8'h09,
      R1   = 8'h05,
      R0   = 8'h08
   } state_t;

   localparam logic [7:0] WALK_LAST = 8'(WALK_FRAMES - 1);
   localparam logic [7:0] ATK_LAST  = 8'(ATK_FRAMES - 1);

   logic   fc_meta_reg, fc_sync_reg, fc_prev_reg, tick_reg;
   state_t state_reg, state_next;
   logic [7:0] cnt_reg, cnt_next;
   logic   pend_reg, pend_next;
   logic   busy_reg, hit_reg, done_reg, done_next;
   logic   walk_wrap, atk_wrap, req_pend;

   assign state       = state_reg;
   assign busy        = busy_reg;
   assign hit         = hit_reg;
   assign attack_done = done_reg;

   assign walk_wrap = tick_reg && (cnt_reg == WALK_LAST);
   assign atk_wrap  = tick_reg && (cnt_reg == ATK_LAST);
   assign req_pend  = pend_reg || attack_req;

   // Synchronise the frame strobe, then register a one-cycle pulse on its rising edge.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         fc_meta_reg <= 1'b0;
         fc_sync_reg <= 1'b0;
         fc_prev_reg <= 1'b0;
         tick_reg    <= 1'b0;
      end else begin
         fc_meta_reg <= frame_clk;
         fc_sync_reg <= fc_meta_reg;
         fc_prev_reg <= fc_sync_reg;
         tick_reg    <= fc_sync_reg & ~fc_prev_reg;
      end
   end

   // Next pose/phase, frame counter and pending-request selection.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      pend_next  = pend_reg;
      done_next  = 1'b0;
      case (state_reg)
         IDLE, WALK: begin
            // An attack start wins over a pose change or a tick in the same cycle.
            if (attack_req) begin
               state_next = A0;
               cnt_next   = 8'd0;
               pend_next  = 1'b0;
            end else if (!move) begin
               state_next = IDLE;
               cnt_next   = 8'd0;
            end else if (walk_wrap) begin
               state_next = (state_reg == IDLE) ? WALK : IDLE;
               cnt_next   = 8'd0;
            end else if (tick_reg) begin
               cnt_next = cnt_reg + 8'd1;
            end
         end
         A0, A1, A2: begin
            if (atk_wrap) begin
               state_next = (state_reg == A0) ? A1 : (state_reg == A1) ? A2 : R1;
               cnt_next   = 8'd0;
            end else if (tick_reg) begin
               cnt_next = cnt_reg + 8'd1;
            end
         end
         R1: begin
            pend_next = req_pend;
            if (atk_wrap) begin
               state_next = R0;
               cnt_next   = 8'd0;
            end else if (tick_reg) begin
               cnt_next = cnt_reg + 8'd1;
            end
         end
         R0: begin
            pend_next = req_pend;
            if (atk_wrap) begin
               // The exit consumes the tick; whatever follows starts from a zero count.
               done_next = 1'b1;
               cnt_next  = 8'd0;
               if (req_pend) begin
                  state_next = A0;
                  pend_next  = 1'b0;
               end else begin
                  state_next = move ? WALK : IDLE;
               end
            end else if (tick_reg) begin
               cnt_next = cnt_reg + 8'd1;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = 8'd0;
            pend_next  = 1'b0;
         end
      endcase
   end

   // State, counter and registered status flags, all aligned with the frame code.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_reg <= IDLE;
         cnt_reg   <= 8'd0;
         pend_reg  <= 1'b0;
         busy_reg  <= 1'b0;
         hit_reg   <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         pend_reg  <= pend_next;
         busy_reg  <= (state_next != IDLE) && (state_next != WALK);
         hit_reg   <= (state_next == A2);
         done_reg  <= done_next;
      end
   end

endmodule
